banner_scroll_ctrl: RTL and testbench

- Sequences reads of a 1-cycle-latency banner column ROM (57-bit column word per address, 129 addresses) and streams one frame of DISP_COLS columns to the LED-matrix column driver over a valid/ready handshake.
- Scrolls the banner horizontally by advancing a wrapping base offset every SCROLL_DIV frames.
- Sits between the frame-timing generator and the column driver. The banner ROM is instantiated alongside it and is driven only by this block.

---
 rtl/banner_pkg.sv | 20 ++
 rtl/banner_scroll_ctrl_if.sv | 28 ++
 rtl/banner_addr_wrap.sv | 29 ++
 rtl/banner_scroll_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_banner_scroll_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/banner_pkg.sv
// Shared parameters and FSM encoding for the banner scroll controller.
// Imported by the controller, its interface and its address adder.
package banner_pkg;

  localparam int ROM_DEPTH  = 129;
  localparam int DATA_W     = 57;
  localparam int ADDR_W     = 8;
  localparam int DISP_COLS  = 32;
  localparam int SCROLL_DIV = 4;
  localparam int IDX_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/banner_scroll_ctrl_if.sv
// Column stream from the scroll controller to the LED column driver.
// Valid/ready handshake; payload is held while valid and not ready.
interface banner_col_if
  import banner_pkg::*;
#(
  parameter int DW = DATA_W
);

  logic [DW-1:0]    col_data;
  logic [IDX_W-1:0] col_idx;
  logic             col_valid;
  logic             col_ready;

  modport master (
    output col_data,
    output col_idx,
    output col_valid,
    input  col_ready
  );

  modport slave (
    input  col_data,
    input  col_idx,
    input  col_valid,
    output col_ready
  );

endinterface

// File: rtl/banner_addr_wrap.sv
// Modulo-ROM_DEPTH adder for operands already below ROM_DEPTH.
// One conditional subtract is enough since a + b < 2*ROM_DEPTH.
module banner_addr_wrap
  import banner_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = ROM_DEPTH
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic [AW-1:0] sum_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW:0] raw;
  logic [AW:0] red;

  // widen, add, fold back into range
  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i};
    red = raw;
    if (raw >= DEPTH_W) begin
      red = raw - DEPTH_W;
    end
    sum_o = red[AW-1:0];
  end

endmodule

// File: rtl/banner_scroll_ctrl.sv
// Fetches DISP_COLS banner columns per frame from a 1-cycle ROM and
// streams them to the column driver; scrolls every SCROLL_DIV frames.
module banner_scroll_ctrl
  import banner_pkg::*;
#(
  parameter int RD   = ROM_DEPTH,
  parameter int DW   = DATA_W,
  parameter int AW   = ADDR_W,
  parameter int COLS = DISP_COLS,
  parameter int DIV  = SCROLL_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          enable,
  input  logic          scroll_clr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  banner_col_if.master  col,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic [AW-1:0] scroll_pos
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [AW-1:0]    scroll_q, scroll_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [AW-1:0] wa_a;
  logic [AW-1:0] wa_b;
  logic [AW-1:0] addr_nxt;
  logic [AW-1:0] scroll_nxt;

  // address of the column about to be fetched
  always_comb begin
    wa_a = base_q;
    wa_b = AW'(cnt_q) + AW'(1);
    if (state_q == ST_IDLE) begin
      wa_a = scroll_q;
      wa_b = '0;
    end
  end

  banner_addr_wrap #(
    .AW    (AW),
    .DEPTH (RD)
  ) u_addr_wrap (
    .a_i   (wa_a),
    .b_i   (wa_b),
    .sum_o (addr_nxt)
  );

  banner_addr_wrap #(
    .AW    (AW),
    .DEPTH (RD)
  ) u_scroll_wrap (
    .a_i   (scroll_q),
    .b_i   (AW'(1)),
    .sum_o (scroll_nxt)
  );

  // frame sequencer and scroll divider next-state
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovr_d    = frame_start && (state_q != ST_IDLE);
    scroll_d = scroll_q;
    div_d    = div_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          base_d  = scroll_q;
          cnt_d   = '0;
          addr_d  = addr_nxt;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data_d  = rom_data;
        idx_d   = cnt_q;
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (col.col_ready) begin
          valid_d = 1'b0;
          if (cnt_q == LAST_COL) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            addr_d  = addr_nxt;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (enable) begin
          if (div_q == DIV_MAX) begin
            div_d    = '0;
            scroll_d = scroll_nxt;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (scroll_clr) begin
      scroll_d = '0;
      div_d    = '0;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      scroll_q <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      scroll_q <= scroll_d;
      div_q    <= div_d;
    end
  end

  assign rom_addr      = addr_q;
  assign col.col_data  = data_q;
  assign col.col_idx   = idx_q;
  assign col.col_valid = valid_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign overrun       = ovr_q;
  assign scroll_pos    = scroll_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with a registered ROM model.
// Table of per-column expectations plus multi-cycle corner sequences.
module tb_banner_scroll_ctrl;
  import banner_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        frame_start = 0;
  logic        enable = 1;
  logic        scroll_clr = 0;
  logic [7:0]  rom_addr;
  logic [56:0] rom_data = '0;
  logic        busy, frame_done, overrun;
  logic [7:0]  scroll_pos;

  banner_col_if #(.DW(57)) cif ();

  banner_scroll_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .enable      (enable),
    .scroll_clr  (scroll_clr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .col         (cif),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .scroll_pos  (scroll_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [56:0] rom_word(input logic [7:0] a);
    if (a == 8'd0) return 57'h7;
    if (a == 8'd30) return {6'h3f, 51'h0};
    return {1'b1, 40'h0, a, ~a};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    int          tag;
    int          col;
    logic [7:0]  addr;
    logic [56:0] data;
  } vec_t;

  vec_t        vt [12];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  cap_addr [32];
  logic [56:0] cap_data [32];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_tag(input int tag);
    for (int i = 0; i < 12; i++) begin
      if (vt[i].tag == tag) begin
        check($sformatf("t%0d_c%0d_addr", tag, vt[i].col),
              64'(cap_addr[vt[i].col]), 64'(vt[i].addr));
        check($sformatf("t%0d_c%0d_data", tag, vt[i].col),
              64'(cap_data[vt[i].col]), 64'(vt[i].data));
      end
    end
  endtask

  task automatic run_frame(input int stall_col, input bit ovr,
                           input int rst_col, input bit clr_done,
                           output int len, output int novr,
                           output bit stab_ok);
    int cyc;
    int stall_left;
    bit done;
    bit chk_drop;
    logic [56:0] hd;
    for (int c = 0; c < 32; c++) begin
      cap_addr[c] = 'x;
      cap_data[c] = 'x;
    end
    len = 0; novr = 0; stab_ok = 1; done = 0; chk_drop = 0;
    stall_left = 10; cyc = 0; hd = '0;
    @(negedge clk);
    frame_start = 1;
    cif.col_ready = 1;
    @(negedge clk);
    frame_start = 0;
    while (!done && cyc < 400) begin
      cyc++;
      if (overrun) novr++;
      if (busy) len++;
      if (chk_drop) begin
        if (cif.col_valid !== 1'b0) stab_ok = 0;
        chk_drop = 0;
      end
      frame_start = 0;
      scroll_clr = 0;
      cif.col_ready = 1;
      if (frame_done) begin
        done = 1;
        if (ovr) frame_start = 1;
        if (clr_done) scroll_clr = 1;
      end else if (cif.col_valid) begin
        if (rst_col == int'(cif.col_idx)) begin
          rst_n = 0;
          done = 1;
        end else if (stall_col == int'(cif.col_idx) && stall_left > 0) begin
          if (stall_left == 10) hd = cif.col_data;
          else if (cif.col_data !== hd) stab_ok = 0;
          cif.col_ready = 0;
          stall_left--;
        end else begin
          cap_data[cif.col_idx] = cif.col_data;
          cap_addr[cif.col_idx] = rom_addr;
          if (stall_col == int'(cif.col_idx)) chk_drop = 1;
          if (ovr && cif.col_idx == 5'd3) frame_start = 1;
        end
      end
      @(negedge clk);
    end
    if (overrun) novr++;
    frame_start = 0;
    scroll_clr = 0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got %0d cycles required done", cyc);
    end
  endtask

  task automatic run_n(input int n);
    int l, v;
    bit s;
    for (int i = 0; i < n; i++) run_frame(-1, 0, -1, 0, l, v, s);
  endtask

  int len, novr;
  bit stab;

  initial begin
    vt[0]  = '{0, 0,  8'd0,   57'h7};
    vt[1]  = '{0, 30, 8'd30,  {6'h3f, 51'h0}};
    vt[2]  = '{0, 31, 8'd31,  rom_word(8'd31)};
    vt[3]  = '{1, 0,  8'd120, rom_word(8'd120)};
    vt[4]  = '{1, 8,  8'd128, rom_word(8'd128)};
    vt[5]  = '{1, 9,  8'd0,   57'h7};
    vt[6]  = '{1, 31, 8'd22,  rom_word(8'd22)};
    vt[7]  = '{2, 0,  8'd0,   57'h7};
    vt[8]  = '{2, 1,  8'd1,   rom_word(8'd1)};
    vt[9]  = '{3, 4,  8'd5,   rom_word(8'd5)};
    vt[10] = '{3, 5,  8'd6,   rom_word(8'd6)};
    vt[11] = '{3, 6,  8'd7,   rom_word(8'd7)};
    cif.col_ready = 1;

    repeat (3) @(negedge clk);
    check("reset_outs",
          64'({rom_addr, cif.col_data, cif.col_idx, cif.col_valid,
               busy, frame_done, overrun, scroll_pos}), 64'(0));
    rst_n = 1;

    run_frame(-1, 0, -1, 0, len, novr, stab);
    check("f1_len", 64'(len), 64'd97);
    check_tag(0);
    run_n(3);
    check("scroll_after_4", 64'(scroll_pos), 64'd1);

    run_frame(5, 0, -1, 0, len, novr, stab);
    check("stall_len", 64'(len), 64'd107);
    check("stall_stable", 64'(stab), 64'd1);
    check_tag(3);

    run_frame(-1, 1, -1, 0, len, novr, stab);
    check("ovr_count", 64'(novr), 64'd2);
    check("ovr_len", 64'(len), 64'd97);
    check("ovr_idle", 64'(busy), 64'd0);

    run_n(474);
    check("scroll_120", 64'(scroll_pos), 64'd120);
    run_frame(-1, 0, -1, 0, len, novr, stab);
    check_tag(1);
    for (int c = 0; c < 32; c++)
      check($sformatf("wrap_addr_%0d", c), 64'(cap_addr[c]),
            64'((120 + c) % 129));
    run_n(35);
    check("scroll_wrap0", 64'(scroll_pos), 64'd0);

    run_n(3);
    run_frame(-1, 0, -1, 1, len, novr, stab);
    check("clr_wins", 64'(scroll_pos), 64'd0);
    run_n(3);
    check("div_cleared", 64'(scroll_pos), 64'd0);
    run_n(1);
    check("scroll_after_clr", 64'(scroll_pos), 64'd1);

    run_frame(-1, 0, 12, 0, len, novr, stab);
    check("midrst_outs",
          64'({rom_addr, cif.col_data, cif.col_idx, cif.col_valid,
               busy, frame_done, overrun, scroll_pos}), 64'(0));
    rst_n = 1;
    novr = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_done) novr++;
    end
    check("midrst_no_done", 64'(novr), 64'd0);
    run_frame(-1, 0, -1, 0, len, novr, stab);
    check("post_rst_len", 64'(len), 64'd97);
    check_tag(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
